// File: rtl/axil_strobe_xbar.sv
// AXI4-Lite slave fanning one register bus out to N_TGT strobe/ack targets.
// Define AXIL_XBAR_STATS_EN to build the saturating timeout/DECERR counters.
module axil_strobe_xbar #(
    parameter int N_TGT   = 6,
    parameter int LOC_W   = 8,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 axilClk,
    input  logic                 axilRst,
    input  logic [31:0]          araddr,
    input  logic                 arvalid,
    output logic                 arready,
    output logic [31:0]          rdata,
    output logic [1:0]           rresp,
    output logic                 rvalid,
    input  logic                 rready,
    input  logic [31:0]          awaddr,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [31:0]          wdata,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [N_TGT-1:0]     tgt_rstr,
    output logic [N_TGT-1:0]     tgt_wstr,
    input  logic [N_TGT-1:0]     tgt_rack,
    input  logic [N_TGT-1:0]     tgt_wack,
    input  logic [32*N_TGT-1:0]  tgt_din,
    output logic [LOC_W-1:0]     tgt_raddr,
    output logic [LOC_W-1:0]     tgt_waddr,
    output logic [31:0]          tgt_wdata,
    output logic [15:0]          cnt_timeout,
    output logic [15:0]          cnt_decerr
);
    // state   | meaning
    // IDLE    | waiting for a read or a complete write request
    // RD_WAIT | read strobe high, waiting for ack or timeout
    // RD_RESP | rvalid held until rready
    // WR_WAIT | write strobe high, waiting for ack or timeout
    // WR_RESP | bvalid held until bready
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

    localparam logic [15:0] TMR_INIT = 16'(TIMEOUT);

    state_t            state;
    logic              last_wr;
    logic [15:0]       tmr;
    logic [SEL_W-1:0]  ar_idx, aw_idx;
    logic [N_TGT-1:0]  ar_dec, aw_dec;
    logic              ar_hit, aw_hit, grant_rd, grant_wr;
    logic              rack_hit, wack_hit, tmr_done;
    logic [31:0]       rd_mux;
    logic              unused_addr;

    assign ar_idx      = araddr[LOC_W+SEL_W+1:LOC_W+2];
    assign aw_idx      = awaddr[LOC_W+SEL_W+1:LOC_W+2];
    assign unused_addr = ^{araddr[31:LOC_W+SEL_W+2], araddr[1:0],
                           awaddr[31:LOC_W+SEL_W+2], awaddr[1:0]};

    // Decoded one-hot is empty exactly when the index is unmapped.
    always_comb begin
        ar_dec = '0;
        aw_dec = '0;
        rd_mux = '0;
        for (int i = 0; i < N_TGT; i++) begin
            ar_dec[i] = (ar_idx == SEL_W'(i));
            aw_dec[i] = (aw_idx == SEL_W'(i));
            if (tgt_rstr[i])
                rd_mux = rd_mux | tgt_din[32*i +: 32];
        end
    end

    assign ar_hit   = |ar_dec;
    assign aw_hit   = |aw_dec;
    assign grant_rd = arvalid & (~(awvalid & wvalid) | last_wr);
    assign grant_wr = awvalid & wvalid & ~grant_rd;
    // The live strobe masks out every ack except the active target's.
    assign rack_hit = |(tgt_rack & tgt_rstr);
    assign wack_hit = |(tgt_wack & tgt_wstr);
    assign tmr_done = (tmr == 16'd1);

    always_ff @(posedge axilClk) begin
        if (!axilRst) begin
            state     <= IDLE;
            last_wr   <= 1'b1;
            tmr       <= '0;
            arready   <= 1'b0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            rvalid    <= 1'b0;
            bvalid    <= 1'b0;
            rresp     <= 2'b00;
            bresp     <= 2'b00;
            rdata     <= '0;
            tgt_rstr  <= '0;
            tgt_wstr  <= '0;
            tgt_raddr <= '0;
            tgt_waddr <= '0;
            tgt_wdata <= '0;
        end else begin
            arready <= 1'b0;
            awready <= 1'b0;
            wready  <= 1'b0;
            case (state)
                IDLE: begin
                    tmr <= TMR_INIT;
                    if (grant_rd) begin
                        arready   <= 1'b1;
                        last_wr   <= 1'b0;
                        tgt_raddr <= araddr[LOC_W+1:2];
                        if (ar_hit) begin
                            tgt_rstr <= ar_dec;
                            state    <= RD_WAIT;
                        end else begin
                            rresp  <= 2'b11;
                            rdata  <= '0;
                            rvalid <= 1'b1;
                            state  <= RD_RESP;
                        end
                    end else if (grant_wr) begin
                        awready   <= 1'b1;
                        wready    <= 1'b1;
                        last_wr   <= 1'b1;
                        tgt_waddr <= awaddr[LOC_W+1:2];
                        tgt_wdata <= wdata;
                        if (aw_hit) begin
                            tgt_wstr <= aw_dec;
                            state    <= WR_WAIT;
                        end else begin
                            bresp  <= 2'b11;
                            bvalid <= 1'b1;
                            state  <= WR_RESP;
                        end
                    end
                end
                RD_WAIT: begin
                    if (rack_hit) begin
                        tgt_rstr <= '0;
                        rdata    <= rd_mux;
                        rresp    <= 2'b00;
                        rvalid   <= 1'b1;
                        state    <= RD_RESP;
                    end else if (tmr_done) begin
                        tgt_rstr <= '0;
                        rdata    <= 32'hDEADBEEF;
                        rresp    <= 2'b10;
                        rvalid   <= 1'b1;
                        state    <= RD_RESP;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                RD_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (wack_hit || tmr_done) begin
                        tgt_wstr <= '0;
                        bresp    <= wack_hit ? 2'b00 : 2'b10;
                        bvalid   <= 1'b1;
                        state    <= WR_RESP;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXIL_XBAR_STATS_EN
    logic dec_evt, to_evt;

    assign dec_evt = (state == IDLE) &&
                     ((grant_rd && !ar_hit) || (grant_wr && !aw_hit));
    assign to_evt  = ((state == RD_WAIT) && !rack_hit && tmr_done) ||
                     ((state == WR_WAIT) && !wack_hit && tmr_done);

    always_ff @(posedge axilClk) begin
        if (!axilRst) begin
            cnt_timeout <= '0;
            cnt_decerr  <= '0;
        end else begin
            if (to_evt && cnt_timeout != 16'hFFFF)
                cnt_timeout <= cnt_timeout + 16'd1;
            if (dec_evt && cnt_decerr != 16'hFFFF)
                cnt_decerr <= cnt_decerr + 16'd1;
        end
    end
`else
    assign cnt_timeout = '0;
    assign cnt_decerr  = '0;
`endif

endmodule

// File: tb/tb_axil_strobe_xbar.sv
// Directed bench for axil_strobe_xbar: transaction-level model plus per-cycle compare.
module tb_axil_strobe_xbar;
    localparam int N  = 6;
    localparam int LW = 8;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          axilClk = 1'b0;
    logic          axilRst = 1'b0;
    logic [31:0]   araddr = '0, awaddr = '0, wdata = '0;
    logic          arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic          arready, rvalid, awready, wready, bvalid;
    logic [31:0]   rdata;
    logic [1:0]    rresp, bresp;
    logic [N-1:0]  tgt_rstr, tgt_wstr;
    logic [N-1:0]  tgt_rack = '0, tgt_wack = '0;
    logic [32*N-1:0] tgt_din;
    logic [LW-1:0] tgt_raddr, tgt_waddr;
    logic [31:0]   tgt_wdata;
    logic [15:0]   cnt_timeout, cnt_decerr;

    always #5 axilClk = ~axilClk;

    axil_strobe_xbar #(.N_TGT(N), .LOC_W(LW), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .axilClk(axilClk), .axilRst(axilRst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .tgt_rstr(tgt_rstr), .tgt_wstr(tgt_wstr),
        .tgt_rack(tgt_rack), .tgt_wack(tgt_wack), .tgt_din(tgt_din),
        .tgt_raddr(tgt_raddr), .tgt_waddr(tgt_waddr), .tgt_wdata(tgt_wdata),
        .cnt_timeout(cnt_timeout), .cnt_decerr(cnt_decerr)
    );

    int errors = 0;
    int checks = 0;
    int n_dec  = 0;
    int n_to   = 0;

    logic [N-1:0] exp_rstr = '0, exp_wstr = '0;
    logic exp_arready = 1'b0, exp_awready = 1'b0, exp_rvalid = 1'b0, exp_bvalid = 1'b0;
    bit   cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare: strobes, ready and valid against the expectation set by the model.
    always @(negedge axilClk) begin
        chk("strobe_onehot", 32'($countones({tgt_rstr, tgt_wstr}) > 1), 32'd0);
        if (cmp_en) begin
            chk("tgt_rstr", 32'(tgt_rstr), 32'(exp_rstr));
            chk("tgt_wstr", 32'(tgt_wstr), 32'(exp_wstr));
            chk("arready",  32'(arready),  32'(exp_arready));
            chk("awready",  32'(awready),  32'(exp_awready));
            chk("wready",   32'(wready),   32'(exp_awready));
            chk("rvalid",   32'(rvalid),   32'(exp_rvalid));
            chk("bvalid",   32'(bvalid),   32'(exp_bvalid));
        end
    end

    function automatic int m_idx(input logic [31:0] a);
        return int'(a[LW+SW+1:LW+2]);
    endfunction

    function automatic logic [LW-1:0] m_loc(input logic [31:0] a);
        return a[LW+1:2];
    endfunction

    // Cycles the strobe stays high: ack cycle if it lands in the window, else the full timeout.
    function automatic int m_scs(input int idx, input int ack_after);
        if (idx >= N) return 0;
        if (ack_after >= 1 && ack_after <= TO) return ack_after;
        return TO;
    endfunction

    function automatic logic [1:0] m_resp(input int idx, input int ack_after);
        if (idx >= N) return 2'b11;
        if (ack_after >= 1 && ack_after <= TO) return 2'b00;
        return 2'b10;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [1:0] r, input logic [31:0] din);
        case (r)
            2'b00:   return din;
            2'b10:   return 32'hDEADBEEF;
            default: return 32'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge axilClk);
        #1;
    endtask

    task automatic clear_exp();
        exp_rstr = '0; exp_wstr = '0;
        exp_arready = 1'b0; exp_awready = 1'b0;
        exp_rvalid = 1'b0; exp_bvalid = 1'b0;
    endtask

    // One access; ack_after = strobe cycle in which the target acks (0 = never), hold = ready-low cycles.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input int ack_after, input int hold);
        int idx, scs, rs;
        logic [1:0]   er;
        logic [31:0]  ed;
        logic [N-1:0] oh;
        idx = m_idx(addr);
        scs = m_scs(idx, ack_after);
        er  = m_resp(idx, ack_after);
        ed  = m_rdata(er, data);
        rs  = (scs > 0) ? scs + 1 : 1;
        oh  = '0;
        if (idx < N) oh[idx] = 1'b1;
        if (er == 2'b11) n_dec++;
        if (er == 2'b10) n_to++;
        if (wr) begin
            awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = addr; arvalid = 1'b1;
            if (idx < N) tgt_din[32*idx +: 32] = data;
        end
        step();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'hFFFF_FFFF; awaddr = 32'hFFFF_FFFF; wdata = ~data;
        for (int c = 1; c <= rs + hold; c++) begin
            exp_arready = !wr && (c == 1);
            exp_awready = wr && (c == 1);
            exp_rstr = (!wr && c <= scs) ? oh : '0;
            exp_wstr = (wr && c <= scs) ? oh : '0;
            exp_rvalid = !wr && (c >= rs);
            exp_bvalid = wr && (c >= rs);
            if (idx < N) begin
                if (wr) tgt_wack[idx] = (c == ack_after);
                else    tgt_rack[idx] = (c == ack_after);
            end
            if (c == 1) begin
                if (wr) begin
                    chk("tgt_waddr", 32'(tgt_waddr), 32'(m_loc(addr)));
                    chk("tgt_wdata", tgt_wdata, data);
                end else begin
                    chk("tgt_raddr", 32'(tgt_raddr), 32'(m_loc(addr)));
                end
            end
            if (c >= rs) begin
                if (wr) begin
                    chk("bresp", 32'(bresp), 32'(er));
                end else begin
                    chk("rresp", 32'(rresp), 32'(er));
                    chk("rdata", rdata, ed);
                end
            end
            rready = !wr && (c == rs + hold);
            bready = wr && (c == rs + hold);
            step();
        end
        rready = 1'b0; bready = 1'b0;
        tgt_rack = '0; tgt_wack = '0;
        clear_exp();
    endtask

    task automatic chk_stats();
`ifdef AXIL_XBAR_STATS_EN
        chk("cnt_decerr",  32'(cnt_decerr),  32'(n_dec));
        chk("cnt_timeout", 32'(cnt_timeout), 32'(n_to));
`else
        chk("cnt_decerr",  32'(cnt_decerr),  32'd0);
        chk("cnt_timeout", 32'(cnt_timeout), 32'd0);
`endif
    endtask

    initial begin
        string seq;
        int    grants;
        for (int i = 0; i < N; i++) tgt_din[32*i +: 32] = 32'hA000_0000 | 32'(i);

        // Reset state
        step(); step();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        chk("rst_raddr", 32'(tgt_raddr), 32'd0);
        chk("rst_waddr", 32'(tgt_waddr), 32'd0);
        chk("rst_wdata", tgt_wdata, 32'h0);
        chk_stats();
        cmp_en = 1'b1;
        step();
        axilRst = 1'b1;
        step();

        // Read idx 2, local 0x05, ack in the 3rd strobe cycle, rready low 5 cycles
        access(1'b0, 32'h0000_0814, 32'h1234_5678, 3, 5);
        chk("pin_raddr", 32'(tgt_raddr), 32'h05);

        // Write idx 1, local 0x10; bit 16 lies above the decoded fields
        access(1'b1, 32'h0001_0440, 32'hCAFE_F00D, 2, 1);
        chk("pin_waddr", 32'(tgt_waddr), 32'h10);
        chk("pin_wdata", tgt_wdata, 32'hCAFE_F00D);

        // AW alone then W alone: never a request
        awaddr = 32'h0000_0400; awvalid = 1'b1;
        repeat (10) step();
        awvalid = 1'b0; wvalid = 1'b1;
        repeat (5) step();
        wvalid = 1'b0;
        step();

        // Unmapped targets
        access(1'b0, 32'h0000_1C00, 32'h0, 0, 2);
        chk_stats();
        access(1'b1, 32'h0000_3C08, 32'h5555_AAAA, 0, 0);

        // Timeout, ack on expiry edge, late ack
        access(1'b0, 32'h0000_0C04, 32'h1111_1111, 0, 1);
        chk_stats();
        access(1'b0, 32'h0000_0C08, 32'h2222_2222, TO, 0);
        access(1'b0, 32'h0000_1004, 32'h3333_3333, TO + 2, 5);
        access(1'b1, 32'h0000_1404, 32'h4444_4444, 0, 0);
        access(1'b1, 32'h0000_0004, 32'h6666_6666, 1, 0);
        chk_stats();

        // Arbitration after reset: both requests held continuously
        cmp_en = 1'b0;
        axilRst = 1'b0; step(); axilRst = 1'b1;
        araddr = 32'h0000_0C00; awaddr = 32'h0000_1000; wdata = 32'h7777_7777;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
        seq = ""; grants = 0;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            step();
            tgt_rack = tgt_rstr; tgt_wack = tgt_wstr;
            chk("dual_ready", 32'(arready & awready), 32'd0);
            if (arready) begin seq = {seq, "R"}; grants++; end
            if (awready) begin seq = {seq, "W"}; grants++; end
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (seq != "RWRW") begin
            errors++;
            $display("FAIL arb_order: got '%s' expected 'RWRW'", seq);
        end
        repeat (8) begin
            step();
            tgt_rack = tgt_rstr; tgt_wack = tgt_wstr;
        end
        tgt_rack = '0; tgt_wack = '0; rready = 1'b0; bready = 1'b0;
        step();

        // Reset during RD_WAIT, then a normal read
        araddr = 32'h0000_1408; arvalid = 1'b1;
        step(); arvalid = 1'b0;
        step(); step();
        chk("pre_rst_rstr", 32'(tgt_rstr), 32'b100000);
        axilRst = 1'b0;
        step();
        axilRst = 1'b1;
        chk("mid_rst_rstr", 32'(tgt_rstr), 32'd0);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_cnt_to", 32'(cnt_timeout), 32'd0);
        chk("mid_rst_cnt_dec", 32'(cnt_decerr), 32'd0);
        n_dec = 0; n_to = 0;
        clear_exp();
        cmp_en = 1'b1;
        step();
        access(1'b0, 32'h0000_140C, 32'h89AB_CDEF, 2, 0);
        chk_stats();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
